// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared 640x480 VGA timing constants and sub-counter sizing.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int c_H_VISIBLE    = 640;
    localparam int c_V_VISIBLE    = 480;
    localparam int c_H_TOTAL      = 800;
    localparam int c_V_TOTAL      = 525;
    localparam int c_H_DISP_START = 144;
    localparam int c_V_DISP_START = 35;
    localparam int c_CNT_W        = 10;

    // Scale factors go up to 8, so a 3-bit sub-counter covers 0..7
    localparam int c_SUB_W        = 3;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/scale_counter.sv
`default_nettype none
// ============================================================================
// Module   : scale_counter
// Brief    : Modulo-N sub-counter with same-cycle restart and terminal count.
// Revision : 1.0
// ============================================================================
module scale_counter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [W-1:0] c_LAST = W'(N - 1);

    logic [W-1:0] r_count;
    logic [W-1:0] w_cur;

    // Restart makes this cycle count as position 0 without a wasted clock
    always_comb begin
        w_cur = i_restart ? '0 : r_count;
        o_tc  = i_enable && (w_cur == c_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tc ? '0 : (w_cur + W'(1));
        end
    end

endmodule : scale_counter
`default_nettype wire

// File: rtl/scaled_pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : scaled_pixel_addr_gen
// Brief    : Maps VGA hcount/vcount onto an integer-scaled image window and
//            emits image column, row and linear memory address.
// Revision : 1.0
// ============================================================================
module scaled_pixel_addr_gen
    import vga_pkg::*;
#(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 96,
    parameter int SCALE_H      = 5,
    parameter int SCALE_V      = 5,
    parameter int H_DISP_START = c_H_DISP_START,
    parameter int V_DISP_START = c_V_DISP_START,
    parameter int X_OFF        = 0,
    parameter int Y_OFF        = 0,
    parameter int XW           = 7,
    parameter int YW           = 7,
    parameter int AW           = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [c_CNT_W-1:0] hcount,
    input  logic [c_CNT_W-1:0] vcount,
    input  logic               mirror_x,
    output logic [XW-1:0]      x_addr,
    output logic [YW-1:0]      y_addr,
    output logic [AW-1:0]      mem_addr,
    output logic               pix_valid,
    output logic               frame_start
);

    localparam logic [10:0]   c_H_LO      = 11'(H_DISP_START + X_OFF);
    localparam logic [10:0]   c_H_HI      = 11'(H_DISP_START + X_OFF + IMG_W * SCALE_H);
    localparam logic [10:0]   c_H_LAST    = 11'(H_DISP_START + X_OFF + IMG_W * SCALE_H - 1);
    localparam logic [10:0]   c_V_LO      = 11'(V_DISP_START + Y_OFF);
    localparam logic [10:0]   c_V_HI      = 11'(V_DISP_START + Y_OFF + IMG_H * SCALE_V);
    localparam logic [XW-1:0] c_X_MAX     = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_MAX     = YW'(IMG_H - 1);
    localparam logic [AW-1:0] c_LINE_STEP = AW'(IMG_W);

    logic [10:0]   w_h;
    logic [10:0]   w_v;
    logic          w_frame_clr;
    logic          w_win;
    logic          w_first_col;
    logic          w_last_col;
    logic          w_h_tc;
    logic          w_v_tc;
    logic [XW-1:0] w_x_cur;
    logic [XW-1:0] w_x_eff;
    logic [AW-1:0] w_addr;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_line_base;
    logic          r_mirror;
    logic          r_aligned;

    always_comb begin
        w_h         = {1'b0, hcount};
        w_v         = {1'b0, vcount};
        w_frame_clr = (hcount == '0) && (vcount == '0);
        // Counters are meaningless after reset until a frame clear realigns them
        w_win       = r_aligned
                      && (w_h >= c_H_LO) && (w_h < c_H_HI)
                      && (w_v >= c_V_LO) && (w_v < c_V_HI);
        w_first_col = (w_h == c_H_LO);
        w_last_col  = (w_h == c_H_LAST);
        w_x_cur     = w_first_col ? '0 : r_x;
        w_x_eff     = r_mirror ? (c_X_MAX - w_x_cur) : w_x_cur;
        w_addr      = r_line_base + AW'(w_x_eff);
    end

    scale_counter #(
        .N (SCALE_H),
        .W (c_SUB_W)
    ) u_h_sub (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_frame_clr),
        .i_restart (w_first_col),
        .i_enable  (w_win),
        .o_tc      (w_h_tc)
    );

    scale_counter #(
        .N (SCALE_V),
        .W (c_SUB_W)
    ) u_v_sub (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_frame_clr),
        .i_restart (1'b0),
        .i_enable  (w_win && w_last_col),
        .o_tc      (w_v_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_mirror    <= 1'b0;
            r_aligned   <= 1'b0;
        end else if (w_frame_clr) begin
            r_y         <= '0;
            r_line_base <= '0;
            r_mirror    <= mirror_x;
            r_aligned   <= 1'b1;
        end else if (w_win) begin
            r_x <= w_x_cur + XW'(w_h_tc);
            // Row saturates so lines past the image never wrap back to row 0
            if (w_last_col && w_v_tc && (r_y != c_Y_MAX)) begin
                r_y         <= r_y + YW'(1);
                r_line_base <= r_line_base + c_LINE_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            x_addr      <= '1;
            y_addr      <= '1;
            mem_addr    <= '1;
        end else begin
            pix_valid   <= w_win;
            frame_start <= w_frame_clr;
            if (w_win) begin
                x_addr   <= w_x_eff;
                y_addr   <= r_y;
                mem_addr <= w_addr;
            end else begin
                x_addr   <= '1;
                y_addr   <= '1;
                mem_addr <= '1;
            end
        end
    end

endmodule : scaled_pixel_addr_gen
`default_nettype wire
